// File: rtl/geet_fifo_pkg.sv
// Shared constants and helpers for the geet FIFO read-side adapter.
package geet_fifo_pkg;

    localparam int unsigned GEET_FIFO_DATA_WIDTH_DEFAULT = 32;
    localparam logic [31:0] GEET_CNT_MAX                 = 32'hFFFF_FFFF;

    // Skid store must be a power of two between 2 and 8 entries.
    function automatic bit skid_depth_legal(input int unsigned depth, input int unsigned log2_depth);
        return (depth >= 32'd2) && (depth <= 32'd8) && (depth == (32'd1 << log2_depth));
    endfunction

endpackage

// File: rtl/geet_skid_store.sv
// Circular register file holding words already read from the FIFO but not yet
// accepted downstream; flush empties it and rewinds both pointers.
module geet_skid_store
    import geet_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GEET_FIFO_DATA_WIDTH_DEFAULT,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned LOG2_DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [LOG2_DEPTH:0]   occ,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int unsigned PTR_W = LOG2_DEPTH;
    localparam int unsigned OCC_W = LOG2_DEPTH + 1;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]                 occ_q, occ_d;
    logic                             valid_q, valid_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
        valid_d = (occ_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            valid_q  <= valid_d;
        end
    end

    assign occ       = occ_q;
    assign valid     = valid_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/geet_fifo_reader.sv
// Valid/ready stream master on the read side of a 1-cycle-latency FIFO.
// Define GEET_FIFO_READER_STATS_EN to build the beat/stall counters.
module geet_fifo_reader
    import geet_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = GEET_FIFO_DATA_WIDTH_DEFAULT,
    parameter int unsigned SKID_DEPTH      = 2,
    parameter int unsigned LOG2_SKID_DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_d_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [31:0]           beat_count,
    output logic [31:0]           stall_count
);

    localparam int unsigned OCC_W = LOG2_SKID_DEPTH + 1;
    localparam int unsigned SUM_W = LOG2_SKID_DEPTH + 2;

    logic             inflight_q, inflight_d;
    logic             pop;
    logic             push;
    logic [OCC_W-1:0] occ;
    logic [SUM_W-1:0] demand;

    // Only read when the word is guaranteed a skid slot on arrival.
    always_comb begin
        pop        = m_valid & m_ready;
        push       = inflight_q & ~flush;
        demand     = SUM_W'(occ) + SUM_W'(inflight_q) - SUM_W'(pop);
        fifo_rd_en = ~fifo_empty & ~flush & (demand < SUM_W'(SKID_DEPTH));
        inflight_d = fifo_rd_en;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    geet_skid_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH),
        .LOG2_DEPTH (LOG2_SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (reset_n),
        .flush     (flush),
        .push      (push),
        .push_data (fifo_d_out),
        .pop       (pop),
        .occ       (occ),
        .valid     (m_valid),
        .head_data (m_data)
    );

`ifdef GEET_FIFO_READER_STATS_EN
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters; flush deliberately leaves them alone.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pop && (beat_cnt_q != GEET_CNT_MAX)) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
        end
        if (m_valid && !m_ready && (stall_cnt_q != GEET_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign beat_count  = beat_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign beat_count  = '0;
    assign stall_count = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(fifo_rd_en && fifo_empty))
            else begin
                $error("geet_fifo_reader: fifo_rd_en while fifo_empty at %0t", $time);
                $stop;
            end
            assert (skid_depth_legal(SKID_DEPTH, LOG2_SKID_DEPTH) && (occ <= OCC_W'(SKID_DEPTH)))
            else begin
                $error("geet_fifo_reader: illegal skid depth or occupancy at %0t", $time);
                $stop;
            end
        end
    end
`endif

endmodule

// File: tb/tb_geet_fifo_reader.sv
// Bench for geet_fifo_reader: emulated FIFO, queue-based reference model, directed tests.
`timescale 1ns/1ps
module tb_geet_fifo_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned D  = 2;
    localparam int unsigned LD = 1;
`ifdef GEET_FIFO_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] fifo_d_out = '0;
    logic [DW-1:0] m_data;
    logic [31:0]   beat_count;
    logic [31:0]   stall_count;

    logic [DW-1:0] fifo_mem [4096];
    int            wr_total = 0;
    int            rd_total = 0;
    assign fifo_empty = (wr_total == rd_total);

    int checks = 0;
    int failures = 0;

    // Reference model: every word read from the FIFO and not yet accepted or
    // discarded, with the cycle at which it becomes visible downstream.
    logic [DW-1:0] mdl_data_q[$];
    int            mdl_rdy_q[$];
    int            cyc = 0;
    int            mdl_beats = 0;
    int            mdl_stalls = 0;
    bit            exp_valid, exp_pop, exp_rd;
    int            backlog;
    logic          rd_s = 1'b0;
    int            rd_pulses = 0;
    logic [DW-1:0] last_pop = '0;

    geet_fifo_reader #(
        .DATA_WIDTH      (DW),
        .SKID_DEPTH      (D),
        .LOG2_SKID_DEPTH (LD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .fifo_empty  (fifo_empty),
        .fifo_d_out  (fifo_d_out),
        .fifo_rd_en  (fifo_rd_en),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .beat_count  (beat_count),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO with registered output and one-cycle read latency.
    always @(posedge clk) begin
        if (rd_s && (rd_total != wr_total)) begin
            fifo_d_out <= fifo_mem[rd_total];
            rd_total   <= rd_total + 1;
        end
    end

    always @(negedge clk or negedge reset_n) begin
        rd_s = fifo_rd_en;
        if (!reset_n) begin
            mdl_data_q.delete();
            mdl_rdy_q.delete();
            mdl_beats  = 0;
            mdl_stalls = 0;
        end else begin
            cyc++;
            exp_valid = (mdl_data_q.size() != 0) && (mdl_rdy_q[0] <= cyc);
            exp_pop   = exp_valid && m_ready;
            backlog   = mdl_data_q.size() - (exp_pop ? 1 : 0);
            exp_rd    = !fifo_empty && !flush && (backlog < int'(D));
            chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
            chk("m_valid", 32'(m_valid), 32'(exp_valid));
            if (exp_valid) chk("m_data", m_data, mdl_data_q[0]);
            chk("beat_count", beat_count, STATS ? 32'(mdl_beats) : 32'd0);
            chk("stall_count", stall_count, STATS ? 32'(mdl_stalls) : 32'd0);
            if (fifo_rd_en) rd_pulses++;
            if (m_valid && m_ready) last_pop = m_data;
            if (exp_pop) begin
                void'(mdl_data_q.pop_front());
                void'(mdl_rdy_q.pop_front());
                mdl_beats++;
            end
            if (exp_valid && !m_ready) mdl_stalls++;
            if (flush) begin
                mdl_data_q.delete();
                mdl_rdy_q.delete();
            end
            if (exp_rd) begin
                mdl_data_q.push_back(fifo_mem[rd_total]);
                mdl_rdy_q.push_back(cyc + 2);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_total] = base + DW'(i);
            wr_total++;
        end
    endtask

    task automatic drain(input string nm);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        tick(1);
        m_ready = 1'b1;
        while ((quiet < 3) && (n < 100)) begin
            @(negedge clk);
            n++;
            if (fifo_empty && !m_valid) quiet++;
            else quiet = 0;
        end
        chk({nm, "_drained"}, 32'(quiet >= 3), 32'd1);
    endtask

    logic          rd_h [14];
    logic          v_h  [14];
    logic [DW-1:0] d_h  [14];
    int            rd_snap;
    int            found;
    int            n_cyc;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_beat", beat_count, 32'd0);
        chk("rst_stall", stall_count, 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        reset_n = 1'b1;

        // Full-rate burst of eight words.
        tick(1);
        m_ready = 1'b1;
        preload(8, 32'hA0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rd_h[i] = fifo_rd_en;
            v_h[i]  = m_valid;
            d_h[i]  = m_data;
        end
        for (int i = 0; i < 8; i++) chk($sformatf("t1_rd%0d", i), 32'(rd_h[i]), 32'd1);
        chk("t1_rd8", 32'(rd_h[8]), 32'd0);
        chk("t1_v1", 32'(v_h[1]), 32'd0);
        for (int i = 2; i < 10; i++) begin
            chk($sformatf("t1_v%0d", i), 32'(v_h[i]), 32'd1);
            chk($sformatf("t1_d%0d", i), d_h[i], 32'hA0 + 32'(i - 2));
        end
        chk("t1_v10", 32'(v_h[10]), 32'd0);
        chk("t1_beats", beat_count, STATS ? 32'd8 : 32'd0);

        // Backpressure: skid fills to two entries and holds.
        tick(1);
        m_ready = 1'b0;
        rd_snap = rd_pulses;
        preload(4, 32'hB0);
        found = 0;
        for (int i = 0; (i < 10) && (found == 0); i++) begin
            @(negedge clk);
            if (m_valid) found = 1;
        end
        chk("t2_valid_seen", 32'(found), 32'd1);
        repeat (10) @(negedge clk);
        chk("t2_rd_pulses", 32'(rd_pulses - rd_snap), 32'd2);
        chk("t2_hold_valid", 32'(m_valid), 32'd1);
        chk("t2_hold_data", m_data, 32'hB0);
        chk("t2_stall", stall_count, STATS ? 32'd10 : 32'd0);
        chk("t2_rd_idle", 32'(fifo_rd_en), 32'd0);
        chk("t2_fifo_backed_up", 32'(fifo_empty), 32'd0);
        drain("t2");
        chk("t2_beats", beat_count, STATS ? 32'd12 : 32'd0);

        // Single word into an idle reader.
        tick(1);
        rd_snap = rd_pulses;
        preload(1, 32'hC0);
        found = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_valid && (m_data == 32'hC0)) found = 1;
        end
        chk("t3_rd_pulses", 32'(rd_pulses - rd_snap), 32'd1);
        chk("t3_seen", 32'(found), 32'd1);
        drain("t3");

        // Random backpressure over 1000 words.
        tick(1);
        preload(1000, 32'h1000_0000);
        found = 0;
        n_cyc = 0;
        while ((found == 0) && (n_cyc < 5000)) begin
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_cyc++;
            if (fifo_empty && !m_valid && (mdl_data_q.size() == 0)) found = 1;
            else tick(1);
        end
        chk("t4_done", 32'(found), 32'd1);
        chk("t4_last", last_pop, 32'h1000_03E7);
        chk("t4_beats", beat_count, STATS ? 32'd1013 : 32'd0);
        drain("t4");

        // Flush one cycle after a read issued with one word already buffered.
        tick(1);
        m_ready = 1'b0;
        preload(1, 32'hD0);
        tick(2);
        preload(2, 32'hD1);
        @(negedge clk);
        chk("t5_rd_pre", 32'(fifo_rd_en), 32'd1);
        chk("t5_valid_pre", 32'(m_valid), 32'd1);
        tick(1);
        flush = 1'b1;
        @(negedge clk);
        chk("t5_rd_flush", 32'(fifo_rd_en), 32'd0);
        tick(1);
        flush = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        chk("t5_valid_post", 32'(m_valid), 32'd0);
        chk("t5_rd_post", 32'(fifo_rd_en), 32'd1);
        tick(1);
        @(negedge clk);
        chk("t5_valid_gap", 32'(m_valid), 32'd0);
        tick(1);
        @(negedge clk);
        chk("t5_valid_next", 32'(m_valid), 32'd1);
        chk("t5_data_next", m_data, 32'hD2);
        drain("t5");
        chk("t5_beats", beat_count, STATS ? 32'd1014 : 32'd0);

        // Asynchronous reset pulse mid-burst.
        tick(1);
        m_ready = 1'b1;
        preload(6, 32'hE0);
        tick(3);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_valid_async", 32'(m_valid), 32'd0);
        chk("t6_data_async", m_data, 32'd0);
        chk("t6_beat_async", beat_count, 32'd0);
        chk("t6_stall_async", stall_count, 32'd0);
        #1 reset_n = 1'b1;
        found = 0;
        for (int i = 0; (i < 6) && (found == 0); i++) begin
            @(negedge clk);
            if (m_valid) found = 1;
        end
        chk("t6_resume", 32'(found), 32'd1);
        chk("t6_first_data", m_data, 32'hE3);
        drain("t6");
        chk("t6_beats", beat_count, STATS ? 32'd3 : 32'd0);
        chk("t6_stalls", stall_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
